// File: rtl/draw_sequencer_pkg.sv
// Shared types and constants for the draw sequencer block.
// Build option DRAW_SEQ_CLEAR_EN adds the CLEAR state to the state enum.
package draw_pkg;

    localparam int COORD_W   = 10;
    localparam int COLOR_W   = 3;
    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3
`ifdef DRAW_SEQ_CLEAR_EN
        ,
        S_CLEAR = 3'd4
`endif
    } state_e;

    // Width of an index into n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_sequencer_if.sv
// Bundle of drawer-side, host-side and VGA-side signals of the draw sequencer.
// The master modport is the sequencer; the slave modport is its environment
// (host, drawers and VGA adapter).
interface draw_sequencer_if #(
    parameter int N_DRAWERS = 4
);
    import draw_pkg::*;

    logic                           frame_start;
    logic [N_DRAWERS-1:0]           enable;
    logic [N_DRAWERS-1:0]           plot;
    logic [N_DRAWERS*COORD_W-1:0]   drawer_x;
    logic [N_DRAWERS*COORD_W-1:0]   drawer_y;
    logic [N_DRAWERS-1:0]           drawer_we;
    logic [N_DRAWERS*COLOR_W-1:0]   drawer_color;
    logic [N_DRAWERS-1:0]           drawer_done;
    logic [COORD_W-1:0]             x;
    logic [COORD_W-1:0]             y;
    logic                           writeEn;
    logic [COLOR_W-1:0]             color;
    logic                           busy;
    logic                           frame_done;
    logic                           timeout_err;

    modport master (
        input  frame_start, enable, drawer_x, drawer_y, drawer_we,
               drawer_color, drawer_done,
        output plot, x, y, writeEn, color, busy, frame_done, timeout_err
    );

    modport slave (
        output frame_start, enable, drawer_x, drawer_y, drawer_we,
               drawer_color, drawer_done,
        input  plot, x, y, writeEn, color, busy, frame_done, timeout_err
    );

endinterface

// File: rtl/draw_sequencer_priority_pick.sv
// Masked lowest-set-bit finder: returns the lowest set bit of req_i whose
// position is at or above ptr_i, or raises none_o when no such bit exists.
module draw_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o
);

    // Scan downwards so the lowest qualifying bit is the last one to win
    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (i >= int'(ptr_i))) begin
                idx_o  = IDX_W'(i);
                none_o = 1'b0;
            end else begin
                idx_o  = idx_o;
                none_o = none_o;
            end
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: starts each enabled sprite drawer in turn, routes the
// selected drawer's pixel stream to the VGA adapter and abandons a drawer
// that does not finish within WAIT_LIMIT cycles.
// Build option DRAW_SEQ_CLEAR_EN: raster-clear the screen with CLEAR_COLOR
// before the drawers run.
module draw_sequencer #(
    parameter int                           N_DRAWERS   = 4,
    parameter int                           H_RES       = draw_pkg::DEF_H_RES,
    parameter int                           V_RES       = draw_pkg::DEF_V_RES,
    parameter logic [draw_pkg::COLOR_W-1:0] CLEAR_COLOR = 3'b000,
    parameter int                           WAIT_LIMIT  = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    draw_sequencer_if.master bus
);
    import draw_pkg::*;

    localparam int IDX_W  = idx_width(N_DRAWERS);
    // The scan pointer must be able to point one past the last drawer
    localparam int PTR_W  = $clog2(N_DRAWERS + 1);
    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    state_e               state_q;
    state_e               state_d;
    logic [N_DRAWERS-1:0] en_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WCNT_W-1:0]    wcnt_q;
    logic                 timeout_q;

    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_none_s;
    logic                 sel_done_s;
    logic                 wait_expired_s;

`ifdef DRAW_SEQ_CLEAR_EN
    logic [COORD_W-1:0]   cx_q;
    logic [COORD_W-1:0]   cy_q;
    logic                 clear_last_s;

    assign clear_last_s = (cx_q == COORD_W'(H_RES - 1)) &&
                          (cy_q == COORD_W'(V_RES - 1));
`endif

    draw_priority_pick #(
        .N     (N_DRAWERS),
        .PTR_W (PTR_W),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (en_q),
        .ptr_i  (ptr_q),
        .idx_o  (pick_idx_s),
        .none_o (pick_none_s)
    );

    // Only the selected drawer's completion flag is considered
    assign sel_done_s     = bus.drawer_done[idx_q];
    assign wait_expired_s = (wcnt_q == WCNT_LAST);
    assign bus.timeout_err = timeout_q;

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; frame_start only matters in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
`ifdef DRAW_SEQ_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_ISSUE;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef DRAW_SEQ_CLEAR_EN
            S_CLEAR: begin
                if (clear_last_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_CLEAR;
                end
            end
`endif
            S_ISSUE: begin
                if (pick_none_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sel_done_s || wait_expired_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame bookkeeping: enable snapshot, scan pointer, wait counter, error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q      <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
`ifdef DRAW_SEQ_CLEAR_EN
            cx_q      <= '0;
            cy_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        en_q      <= bus.enable;
                        ptr_q     <= '0;
                        wcnt_q    <= '0;
                        timeout_q <= 1'b0;
`ifdef DRAW_SEQ_CLEAR_EN
                        cx_q      <= '0;
                        cy_q      <= '0;
`endif
                    end
                end
`ifdef DRAW_SEQ_CLEAR_EN
                S_CLEAR: begin
                    if (cx_q == COORD_W'(H_RES - 1)) begin
                        cx_q <= '0;
                        if (cy_q == COORD_W'(V_RES - 1)) begin
                            cy_q <= '0;
                        end else begin
                            cy_q <= cy_q + COORD_W'(1);
                        end
                    end else begin
                        cx_q <= cx_q + COORD_W'(1);
                    end
                end
`endif
                S_ISSUE: begin
                    if (!pick_none_s) begin
                        idx_q  <= pick_idx_s;
                        wcnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    // Completion wins over a simultaneous timeout
                    if (sel_done_s) begin
                        ptr_q <= PTR_W'(idx_q) + PTR_W'(1);
                    end else if (wait_expired_s) begin
                        ptr_q     <= PTR_W'(idx_q) + PTR_W'(1);
                        timeout_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; pixel bus is live only while clearing or waiting on a drawer
    always_comb begin
        bus.plot       = '0;
        bus.x          = '0;
        bus.y          = '0;
        bus.writeEn    = 1'b0;
        bus.color      = '0;
        bus.busy       = (state_q != S_IDLE);
        bus.frame_done = 1'b0;
        case (state_q)
`ifdef DRAW_SEQ_CLEAR_EN
            S_CLEAR: begin
                bus.x       = cx_q;
                bus.y       = cy_q;
                bus.writeEn = 1'b1;
                bus.color   = CLEAR_COLOR;
            end
`endif
            S_ISSUE: begin
                if (!pick_none_s) begin
                    bus.plot[pick_idx_s] = 1'b1;
                end else begin
                    bus.plot = '0;
                end
            end
            S_WAIT: begin
                bus.x       = bus.drawer_x[idx_q*COORD_W +: COORD_W];
                bus.y       = bus.drawer_y[idx_q*COORD_W +: COORD_W];
                bus.writeEn = bus.drawer_we[idx_q];
                bus.color   = bus.drawer_color[idx_q*COLOR_W +: COLOR_W];
            end
            S_DONE: begin
                bus.frame_done = 1'b1;
            end
            default: begin
                bus.frame_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer (4 drawers, 4x2 screen, WAIT_LIMIT 16).
// Clear-pass checks are compiled only when DRAW_SEQ_CLEAR_EN is defined.
`timescale 1ns/1ps
module tb_draw_sequencer;

`ifdef DRAW_SEQ_CLEAR_EN
    localparam int CLR = 8;
`else
    localparam int CLR = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    draw_sequencer_if #(.N_DRAWERS(4)) bus ();

    draw_sequencer #(
        .N_DRAWERS   (4),
        .H_RES       (4),
        .V_RES       (2),
        .CLEAR_COLOR (3'b000),
        .WAIT_LIMIT  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.frame_start  = 1'b0;
        bus.enable       = 4'b0000;
        bus.drawer_x     = 40'd0;
        bus.drawer_y     = 40'd0;
        bus.drawer_we    = 4'b0000;
        bus.drawer_color = 12'd0;
        bus.drawer_done  = 4'b0000;
    endtask

    // Leaves the bench in the first ISSUE cycle of a new frame
    task automatic start_frame(input logic [3:0] en);
        bus.enable      = en;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        repeat (CLR) step();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({bus.plot, bus.x, bus.y, bus.writeEn, bus.color, bus.busy,
             bus.frame_done, bus.timeout_err} !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs: plot=%b x=%0d y=%0d we=%b color=%b busy=%b fd=%b to=%b, expected all 0",
                     bus.plot, bus.x, bus.y, bus.writeEn, bus.color, bus.busy, bus.frame_done, bus.timeout_err);
        end
        bus.frame_start = 1'b1;
        repeat (2) step();
        vecs++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_holds_idle: busy=%b, expected 0", bus.busy);
        end
        bus.frame_start = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_empty_frame();
        bus.enable      = 4'b0000;
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        vecs++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL empty_cycle1: fd=%b busy=%b, expected fd=0 busy=1", bus.frame_done, bus.busy);
        end
        repeat (CLR) step();
        step();
        vecs++;
        if (bus.frame_done !== 1'b1) begin
            errs++;
            $display("FAIL empty_cycle2: fd=%b, expected 1", bus.frame_done);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL empty_idle: fd=%b busy=%b, expected 0 0", bus.frame_done, bus.busy);
        end
    endtask

    task automatic test_two_drawers();
        logic bad;
        start_frame(4'b1010);
        vecs++;
        if (bus.plot !== 4'b0010 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL seq_plot1: plot=%b busy=%b, expected 0010 1", bus.plot, bus.busy);
        end
        bad = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (bus.plot !== 4'b0000 || bus.busy !== 1'b1) bad = 1'b1;
        end
        step();
        bus.drawer_done = 4'b0010;
        if (bus.plot !== 4'b0000) bad = 1'b1;
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL seq_wait1: plot nonzero or busy low while waiting on drawer 1, expected plot=0000 busy=1");
        end
        step();
        bus.drawer_done = 4'b0000;
        vecs++;
        if (bus.plot !== 4'b1000) begin
            errs++;
            $display("FAIL seq_plot3: plot=%b, expected 1000", bus.plot);
        end
        repeat (8) step();
        bus.drawer_done = 4'b1000;
        step();
        bus.drawer_done = 4'b0000;
        vecs++;
        if (bus.plot !== 4'b0000 || bus.frame_done !== 1'b0 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL seq_last_issue: plot=%b fd=%b busy=%b, expected 0000 0 1", bus.plot, bus.frame_done, bus.busy);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b1 || bus.timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL seq_frame_done: fd=%b to=%b, expected 1 0", bus.frame_done, bus.timeout_err);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL seq_idle: fd=%b busy=%b, expected 0 0", bus.frame_done, bus.busy);
        end
    endtask

    task automatic test_pixel_mux();
        bus.drawer_x     = {10'd0, 10'd5, 10'd0, 10'd9};
        bus.drawer_y     = {10'd0, 10'd7, 10'd0, 10'd3};
        bus.drawer_color = {3'b000, 3'b101, 3'b000, 3'b111};
        bus.drawer_we    = 4'b0101;
        #1;
        vecs++;
        if (bus.writeEn !== 1'b0 || bus.x !== 10'd0 || bus.y !== 10'd0 || bus.color !== 3'b000) begin
            errs++;
            $display("FAIL mux_idle_quiet: we=%b x=%0d y=%0d color=%b, expected 0 0 0 000", bus.writeEn, bus.x, bus.y, bus.color);
        end
        start_frame(4'b0100);
        vecs++;
        if (bus.plot !== 4'b0100 || bus.writeEn !== 1'b0 || bus.x !== 10'd0) begin
            errs++;
            $display("FAIL mux_issue: plot=%b we=%b x=%0d, expected 0100 0 0", bus.plot, bus.writeEn, bus.x);
        end
        step();
        vecs++;
        if (bus.x !== 10'd5 || bus.y !== 10'd7 || bus.writeEn !== 1'b1 || bus.color !== 3'b101) begin
            errs++;
            $display("FAIL mux_pixel: x=%0d y=%0d we=%b color=%b, expected 5 7 1 101", bus.x, bus.y, bus.writeEn, bus.color);
        end
        bus.drawer_we   = 4'b0001;
        bus.drawer_done = 4'b1011;
        #1;
        vecs++;
        if (bus.writeEn !== 1'b0 || bus.x !== 10'd5) begin
            errs++;
            $display("FAIL mux_we_follows_sel: we=%b x=%0d, expected 0 5", bus.writeEn, bus.x);
        end
        step();
        bus.drawer_done = 4'b0000;
        vecs++;
        if (bus.busy !== 1'b1 || bus.plot !== 4'b0000 || bus.x !== 10'd5 || bus.frame_done !== 1'b0) begin
            errs++;
            $display("FAIL mux_foreign_done: busy=%b plot=%b x=%0d fd=%b, expected 1 0000 5 0", bus.busy, bus.plot, bus.x, bus.frame_done);
        end
        bus.drawer_done = 4'b0100;
        step();
        bus.drawer_done = 4'b0000;
        vecs++;
        if (bus.plot !== 4'b0000 || bus.writeEn !== 1'b0 || bus.x !== 10'd0) begin
            errs++;
            $display("FAIL mux_after_done: plot=%b we=%b x=%0d, expected 0000 0 0", bus.plot, bus.writeEn, bus.x);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b1) begin
            errs++;
            $display("FAIL mux_frame_done: fd=%b, expected 1", bus.frame_done);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic bad;
        start_frame(4'b0001);
        vecs++;
        if (bus.plot !== 4'b0001) begin
            errs++;
            $display("FAIL to_plot0: plot=%b, expected 0001", bus.plot);
        end
        bad = 1'b0;
        for (int w = 1; w <= 16; w++) begin
            step();
            if (bus.busy !== 1'b1 || bus.plot !== 4'b0000 || bus.timeout_err !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL to_wait16: timeout_err or plot changed before 16 wait cycles, expected to=0 plot=0000");
        end
        step();
        vecs++;
        if (bus.timeout_err !== 1'b1 || bus.frame_done !== 1'b0) begin
            errs++;
            $display("FAIL to_flag: to=%b fd=%b, expected 1 0", bus.timeout_err, bus.frame_done);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b1) begin
            errs++;
            $display("FAIL to_frame_done: fd=%b, expected 1", bus.frame_done);
        end
        step();
        vecs++;
        if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL to_sticky: to=%b busy=%b, expected 1 0", bus.timeout_err, bus.busy);
        end
    endtask

    task automatic test_done_beats_timeout();
        start_frame(4'b0001);
        vecs++;
        if (bus.timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL prio_cleared: to=%b, expected 0 after frame_start", bus.timeout_err);
        end
        repeat (16) step();
        bus.drawer_done = 4'b0001;
        step();
        bus.drawer_done = 4'b0000;
        vecs++;
        if (bus.timeout_err !== 1'b0) begin
            errs++;
            $display("FAIL prio_done_wins: to=%b, expected 0", bus.timeout_err);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b1) begin
            errs++;
            $display("FAIL prio_frame_done: fd=%b, expected 1", bus.frame_done);
        end
        step();
    endtask

    task automatic test_start_while_busy();
        int plots;
        int fdones;
        plots  = 0;
        fdones = 0;
        bus.enable      = 4'b0010;
        bus.frame_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            bus.frame_start = (c == 1 || c == 3 + CLR || c == 8 + CLR) ? 1'b1 : 1'b0;
            bus.drawer_done = (c == 6 + CLR) ? 4'b0010 : 4'b0000;
            #1;
            if (bus.plot !== 4'b0000) plots++;
            if (bus.frame_done === 1'b1) fdones++;
        end
        vecs++;
        if (plots != 1 || fdones != 1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL busy_start_ignored: plot_cycles=%0d frame_done=%0d busy=%b, expected 1 1 0", plots, fdones, bus.busy);
        end
        clear_inputs();
    endtask

`ifdef DRAW_SEQ_CLEAR_EN
    task automatic test_clear_pass();
        logic bad;
        bad = 1'b0;
        bus.enable      = 4'b0000;
        bus.frame_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            bus.frame_start = 1'b0;
            if (bus.x !== 10'(k % 4) || bus.y !== 10'(k / 4) || bus.writeEn !== 1'b1 || bus.color !== 3'b000)
                bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL clear_raster: pixel sequence differs from (0,0)..(3,1) with we=1 color=000");
        end
        step();
        vecs++;
        if (bus.writeEn !== 1'b0 || bus.frame_done !== 1'b0) begin
            errs++;
            $display("FAIL clear_to_issue: we=%b fd=%b, expected 0 0", bus.writeEn, bus.frame_done);
        end
        step();
        vecs++;
        if (bus.frame_done !== 1'b1) begin
            errs++;
            $display("FAIL clear_frame_done: fd=%b, expected 1", bus.frame_done);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid_wait();
        logic bad;
        bus.drawer_x     = {10'd0, 10'd5, 10'd0, 10'd0};
        bus.drawer_y     = {10'd0, 10'd7, 10'd0, 10'd0};
        bus.drawer_color = {3'b000, 3'b101, 3'b000, 3'b000};
        bus.drawer_we    = 4'b0100;
        start_frame(4'b0100);
        step();
        vecs++;
        if (bus.writeEn !== 1'b1 || bus.busy !== 1'b1) begin
            errs++;
            $display("FAIL rst_pre_wait: we=%b busy=%b, expected 1 1", bus.writeEn, bus.busy);
        end
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({bus.plot, bus.x, bus.y, bus.writeEn, bus.color, bus.busy,
             bus.frame_done, bus.timeout_err} !== 32'd0) begin
            errs++;
            $display("FAIL rst_immediate: plot=%b x=%0d y=%0d we=%b color=%b busy=%b fd=%b to=%b, expected all 0",
                     bus.plot, bus.x, bus.y, bus.writeEn, bus.color, bus.busy, bus.frame_done, bus.timeout_err);
        end
        step();
        reset_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.busy !== 1'b0 || bus.plot !== 4'b0000 || bus.writeEn !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL rst_no_resume: sequencer active after reset release, expected busy=0 plot=0000 we=0");
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_two_drawers();
        test_pixel_mux();
        test_timeout();
        test_done_beats_timeout();
        test_start_while_busy();
`ifdef DRAW_SEQ_CLEAR_EN
        test_clear_pass();
`endif
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/draw_sequencer.md
DRAW_SEQUENCER -- requirements
Module: draw_sequencer

Interface
- REQ-001: Parameter N_DRAWERS, default 4: number of sprite drawers sequenced.
- REQ-002: Parameter H_RES, default 320: screen width in pixels.
- REQ-003: Parameter V_RES, default 240: screen height in pixels.
- REQ-004: Parameter CLEAR_COLOR, default 3'b000: colour written during the clear pass.
- REQ-005: Parameter WAIT_LIMIT, default 1024: maximum cycles allowed per drawer before abandoning it.
- REQ-006: Port clk, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
- REQ-007: Port reset_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-008: Port frame_start, input, 1 bit: single-cycle request to redraw a frame.
- REQ-009: Port enable, input, N_DRAWERS bits: per-drawer participation mask.
- REQ-010: Port plot, output, N_DRAWERS bits: one-hot start pulse to each drawer.
- REQ-011: Ports drawer_x and drawer_y, input, N_DRAWERS*10 bits each: packed drawer pixel coordinates.
- REQ-012: Port drawer_we, input, N_DRAWERS bits: per-drawer pixel write strobes.
- REQ-013: Port drawer_color, input, N_DRAWERS*3 bits: packed drawer pixel colours.
- REQ-014: Port drawer_done, input, N_DRAWERS bits: per-drawer completion flags.
- REQ-015: Ports x and y, output, 10 bits each: pixel coordinate to the VGA adapter.
- REQ-016: Port writeEn, output, 1 bit: pixel write strobe to the VGA adapter.
- REQ-017: Port color, output, 3 bits: pixel colour to the VGA adapter.
- REQ-018: Port busy, output, 1 bit: high in every state except IDLE.
- REQ-019: Port frame_done, output, 1 bit: one-cycle pulse marking the end of a frame.
- REQ-020: Port timeout_err, output, 1 bit: sticky flag set when any drawer timed out in the current frame.

Function
- REQ-021: The state machine SHALL have states IDLE, CLEAR, ISSUE, WAIT and DONE.
- REQ-022: In IDLE, frame_start=1 SHALL register enable into en_q, clear timeout_err, and move to CLEAR (macro defined) or ISSUE (macro undefined).
- REQ-023: frame_start SHALL be ignored in every state other than IDLE.
- REQ-024: ISSUE SHALL select idx = lowest-numbered set bit of en_q at or above the scan pointer; if no bit remains, it SHALL go to DONE.
- REQ-025: ISSUE SHALL drive plot[idx]=1 for exactly one cycle, then go to WAIT with the wait counter at 0.
- REQ-026: In WAIT, x, y, writeEn and color SHALL be combinationally muxed from drawer idx; plot SHALL be 0.
- REQ-027: In WAIT, drawer_done[idx]=1 SHALL set the scan pointer to idx+1 and return to ISSUE on the next cycle.
- REQ-028: drawer_done from non-selected drawers SHALL be ignored.
- REQ-029: If the wait counter reaches WAIT_LIMIT-1 without done: set timeout_err, advance the scan pointer, go to ISSUE.
- REQ-030: If done and timeout coincide, done SHALL take priority and timeout_err SHALL NOT be set.
- REQ-031: DONE SHALL pulse frame_done for one cycle and return to IDLE.
- REQ-032: With en_q=0 (and the macro undefined), frame_done SHALL rise 2 cycles after frame_start (IDLE->ISSUE->DONE).
- REQ-033: Outside WAIT and CLEAR, writeEn SHALL be 0 and x, y, color SHALL be 0.

Reset
- REQ-034: reset_n=0 SHALL immediately force IDLE, whatever the current state.
- REQ-035: During reset, plot, x, y, writeEn, color, busy, frame_done, timeout_err, en_q, the counters and the scan pointer SHALL all be 0.
- REQ-036: A frame interrupted by reset SHALL NOT resume after reset is released.

Configuration
- REQ-037: With DRAW_SEQ_CLEAR_EN defined, CLEAR SHALL raster x 0..H_RES-1 (inner loop) and y 0..V_RES-1 (outer loop), one pixel per cycle, with writeEn=1 and color=CLEAR_COLOR.
- REQ-038: The clear pass SHALL take H_RES*V_RES cycles; after pixel (H_RES-1, V_RES-1) the machine SHALL go to ISSUE.
- REQ-039: Without DRAW_SEQ_CLEAR_EN, the CLEAR state and its counters SHALL be absent and IDLE SHALL go directly to ISSUE.

Structure
- REQ-040: A shared package draw_pkg SHALL hold the state enum, COORD_W=10, COLOR_W=3 and the default H_RES/V_RES.
- REQ-041: Sub-module draw_priority_pick (masked lowest-set-bit finder returning idx and a none flag) SHALL be used by ISSUE.

Verification
- REQ-042: Macro undefined, enable=4'b1010, each drawer asserts done 8 cycles after its plot -> plot[1] pulses, then plot[3] pulses; frame_done fires once; timeout_err=0.
- REQ-043: Drawer 2 emits we=1, x=5, y=7, color=3'b101 while selected -> outputs x=5, y=7, writeEn=1, color=3'b101 in the same cycle.
- REQ-044: enable=4'b0001, drawer 0 never asserts done, WAIT_LIMIT=16 -> plot[0] pulses, then after 16 WAIT cycles timeout_err=1 and frame_done pulses.
- REQ-045: Macro defined, H_RES=4, V_RES=2, enable=0 -> 8 writes (0,0)..(3,1) with color=0, then frame_done.
- REQ-046: reset_n dropped mid-WAIT -> all outputs 0 immediately; after release, busy=0 until the next frame_start.
- REQ-047: frame_start pulsed while busy=1 -> no extra plot pulse and exactly one frame_done.
